// File: rtl/spi_buffer_readback.sv
// SPI mode-0 readback slave: decodes a command/address header on MOSI and
// streams image-buffer bytes (or a repeating status byte) back over MISO.
// All SPI inputs are asynchronous and oversampled on sys_clk.
`timescale 1ns/1ps
module spi_buffer_readback #(
   parameter int         ADDR_WIDTH = 15,
   parameter int         BUF_DEPTH  = 32768,
   parameter logic [5:0] VERSION    = 6'h01
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  spi_sclk,
   input  logic                  spi_mosi,
   input  logic                  rb_cs_n,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   output logic                  bram_rd_en,
   output logic [ADDR_WIDTH-1:0] bram_rd_addr,
   input  logic [7:0]            bram_rd_data,
   input  logic                  frame_ready,
   input  logic                  receiving,
   output logic                  busy,
   output logic [15:0]           bytes_sent
);

   localparam logic [31:0]           DEPTH_U  = BUF_DEPTH;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR_HI, ADDR_LO, DUMMY, DATA, STATUS, IGNORE
   } state_t;

   state_t state, next_state;

   logic sclk_s1, sclk_s2, sclk_s3;
   logic mosi_s1, mosi_s2;
   logic cs_s1, cs_s2, cs_s3;
   logic [1:0] init_cnt;
   logic       init_done;
   logic       armed;

   logic       active, cs_fall, rise_ev, fall_ev, byte_done, load_ev;
   logic [2:0] bit_cnt;
   logic       dummy_rx;
   logic       rd_pend;

   logic [6:0]            rx_shift;
   logic [7:0]            rx_byte;
   logic [7:0]            shift_reg;
   logic [7:0]            prefetch_reg;
   logic [7:0]            status_byte;
   logic [ADDR_WIDTH-9:0] addr_hi;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic                  start_ok;

   // Saturating increment for the byte counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Buffer address increment that wraps from BUF_DEPTH-1 back to 0.
   function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
      if ({{(32-ADDR_WIDTH){1'b0}}, a} == DEPTH_U - 32'd1)
         return '0;
      return a + ADDR_ONE;
   endfunction

   assign init_done  = &init_cnt;
   assign active     = (state != IDLE) && !cs_s2;
   assign cs_fall    = armed && cs_s3 && !cs_s2;
   assign rise_ev    = active && sclk_s2 && !sclk_s3;
   assign fall_ev    = active && !sclk_s2 && sclk_s3;
   assign byte_done  = rise_ev && (bit_cnt == 3'd7);
   assign load_ev    = fall_ev && (bit_cnt == 3'd0);
   assign rx_byte    = {rx_shift, mosi_s2};
   assign start_addr = {addr_hi, rx_byte};
   assign start_ok   = {{(32-ADDR_WIDTH){1'b0}}, start_addr} < DEPTH_U;

   assign busy        = (state != IDLE);
   assign spi_miso_oe = busy && !cs_s2;
   assign spi_miso    = spi_miso_oe && shift_reg[7];

   // Two-flop synchronizers plus a third sclk/cs copy for edge detection.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sclk_s1 <= 1'b1; sclk_s2 <= 1'b1; sclk_s3 <= 1'b1;
         mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
         cs_s1   <= 1'b1; cs_s2   <= 1'b1; cs_s3   <= 1'b1;
      end else begin
         sclk_s1 <= spi_sclk; sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
         mosi_s1 <= spi_mosi; mosi_s2 <= mosi_s1;
         cs_s1   <= rb_cs_n;  cs_s2   <= cs_s1;   cs_s3   <= cs_s2;
      end
   end

   // CS must be seen high through the synchronizer before a fall counts, so a
   // CS held low across reset cannot restart a transaction.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         init_cnt <= 2'd0;
         armed    <= 1'b0;
      end else begin
         if (!init_done)
            init_cnt <= init_cnt + 2'd1;
         if (init_done && cs_s2)
            armed <= 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // FSM next-state: header decode at byte boundaries, CS release wins everywhere.
   always_comb begin
      next_state = state;
      if (state == IDLE) begin
         if (cs_fall)
            next_state = CMD;
      end else if (cs_s2) begin
         next_state = IDLE;
      end else begin
         case (state)
            CMD: if (byte_done) begin
               if (rx_byte == 8'h0B)      next_state = ADDR_HI;
               else if (rx_byte == 8'h05) next_state = STATUS;
               else                       next_state = IGNORE;
            end
            ADDR_HI: if (byte_done) next_state = ADDR_LO;
            ADDR_LO: if (byte_done) next_state = DUMMY;
            DUMMY:   if (load_ev && dummy_rx) next_state = DATA;
            default: ;
         endcase
      end
   end

   // Control: bit counter, read strobe/address, prefetch tracking, byte count.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bit_cnt      <= 3'd0;
         dummy_rx     <= 1'b0;
         rd_pend      <= 1'b0;
         bram_rd_en   <= 1'b0;
         bram_rd_addr <= '0;
         bytes_sent   <= 16'd0;
      end else begin
         bram_rd_en <= 1'b0;
         rd_pend    <= bram_rd_en;
         if (rd_pend)
            bram_rd_addr <= wrap_inc(bram_rd_addr);
         if (cs_fall) begin
            bit_cnt    <= 3'd0;
            dummy_rx   <= 1'b0;
            bytes_sent <= 16'd0;
         end else if (rise_ev) begin
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (byte_done && state == DUMMY)
            dummy_rx <= 1'b1;
         if (byte_done && state == ADDR_LO) begin
            bram_rd_addr <= start_ok ? start_addr : '0;
            bram_rd_en   <= 1'b1;
         end
         if (load_ev && ((state == DUMMY && dummy_rx) || state == DATA))
            bram_rd_en <= 1'b1;
         if (load_ev && state == DATA)
            bytes_sent <= sat_inc16(bytes_sent);
      end
   end

   // Datapath: MOSI deserializer, MISO shifter, prefetch and status capture.
   always_ff @(posedge sys_clk) begin
      if (rise_ev)
         rx_shift <= rx_byte[6:0];
      if (rd_pend)
         prefetch_reg <= bram_rd_data;
      if (byte_done && state == ADDR_HI)
         addr_hi <= rx_byte[ADDR_WIDTH-9:0];
      if (byte_done && ((state == CMD && rx_byte == 8'h05) || state == STATUS))
         status_byte <= {frame_ready, receiving, VERSION};
      if (cs_fall) begin
         shift_reg <= 8'h00;
      end else if (load_ev) begin
         case (state)
            STATUS:  shift_reg <= status_byte;
            DUMMY:   shift_reg <= dummy_rx ? prefetch_reg : 8'h00;
            DATA:    shift_reg <= prefetch_reg;
            default: shift_reg <= 8'h00;
         endcase
      end else if (fall_ev) begin
         shift_reg <= {shift_reg[6:0], 1'b0};
      end
   end

endmodule

// File: tb/tb_spi_buffer_readback.sv
// Self-checking bench for spi_buffer_readback: a full-depth instance and a
// BUF_DEPTH=1024 instance share SCLK/MOSI and have separate chip selects.
`timescale 1ns/1ps
module tb_spi_buffer_readback;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        spi_sclk = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        rb_cs_n = 1'b1;
   logic        rb2_cs_n = 1'b1;
   logic        frame_ready = 1'b0;
   logic        receiving = 1'b0;

   logic        spi_miso, spi_miso_oe, bram_rd_en, busy;
   logic [14:0] bram_rd_addr;
   logic [7:0]  bram_rd_data = 8'h00;
   logic [15:0] bytes_sent;

   logic        miso2, miso2_oe, rd_en2, busy2;
   logic [14:0] rd_addr2;
   logic [7:0]  rd_data2 = 8'h00;
   logic [15:0] bytes_sent2;

   int errors = 0;
   int checks = 0;
   int oe_seen = 0;

   logic [7:0]  exp_q[$];
   logic [14:0] rd_log[$];
   logic [14:0] rd_log2[$];

   spi_buffer_readback dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .rb_cs_n(rb_cs_n), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
      .frame_ready(frame_ready), .receiving(receiving), .busy(busy), .bytes_sent(bytes_sent)
   );

   spi_buffer_readback #(.BUF_DEPTH(1024)) dut_small (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .rb_cs_n(rb2_cs_n), .spi_miso(miso2), .spi_miso_oe(miso2_oe),
      .bram_rd_en(rd_en2), .bram_rd_addr(rd_addr2), .bram_rd_data(rd_data2),
      .frame_ready(frame_ready), .receiving(receiving), .busy(busy2), .bytes_sent(bytes_sent2)
   );

   always #5 sys_clk = ~sys_clk;

   // Buffer contents model.
   function automatic logic [7:0] mem_f(input logic [14:0] a);
      case (a)
         15'h0010: return 8'hA1;
         15'h0011: return 8'hB2;
         15'h0012: return 8'hC3;
         15'h0013: return 8'hD4;
         default:  return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
      endcase
   endfunction

   // Synchronous-read BRAM models that also log every read address.
   always @(posedge sys_clk) begin
      if (bram_rd_en) begin
         bram_rd_data <= mem_f(bram_rd_addr);
         rd_log.push_back(bram_rd_addr);
      end
      if (rd_en2) begin
         rd_data2 <= mem_f(rd_addr2);
         rd_log2.push_back(rd_addr2);
      end
      if (spi_miso_oe || spi_miso)
         oe_seen <= oe_seen + 1;
   end

   // Mode-0 master: MOSI set and MISO sampled while SCLK low, 60 ns per phase.
   task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit sel,
                           output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_mosi = tx[i];
         #60;
         rx[i] = sel ? miso2 : spi_miso;
         spi_sclk = 1'b1;
         #60;
         spi_sclk = 1'b0;
      end
   endtask

   task automatic cs_start(input bit sel);
      @(negedge sys_clk);
      if (sel) rb2_cs_n = 1'b0; else rb_cs_n = 1'b0;
      #100;
   endtask

   task automatic cs_stop(input bit sel);
      #60;
      if (sel) rb2_cs_n = 1'b1; else rb_cs_n = 1'b1;
      #100;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
      checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", spi_miso_oe); end
      checks++; if (bram_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bram_rd_en); end
      checks++; if (bram_rd_addr !== 15'h0) begin errors++; $display("FAIL reset_rd_addr: got %h want 0", bram_rd_addr); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (bytes_sent !== 16'h0) begin errors++; $display("FAIL reset_bytes_sent: got %h want 0", bytes_sent); end
      sys_rst_n = 1'b1;
      repeat (10) @(negedge sys_clk);
      checks++; if (busy !== 1'b0 || spi_miso_oe !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy=%b oe=%b want 0 0", busy, spi_miso_oe); end
   endtask

   task automatic test_read_basic();
      logic [7:0] tx [0:7];
      logic [7:0] rx, exp;
      tx = '{8'h0B, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      rd_log.delete();
      repeat (4) exp_q.push_back(8'h00);
      exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
      cs_start(0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
      checks++; if (spi_miso_oe !== 1'b1) begin errors++; $display("FAIL basic_oe: got %b want 1", spi_miso_oe); end
      for (int i = 0; i < 8; i++) begin
         spi_xfer(tx[i], 8, 0, rx);
         exp = exp_q.pop_front();
         checks++; if (rx !== exp) begin errors++; $display("FAIL basic_byte%0d: got %02h want %02h", i, rx, exp); end
      end
      #60;
      checks++; if (bytes_sent !== 16'd4) begin errors++; $display("FAIL basic_bytes_sent: got %0d want 4", bytes_sent); end
      checks++;
      if (rd_log.size() < 5) begin
         errors++; $display("FAIL basic_rd_count: got %0d want >=5", rd_log.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            checks++; if (rd_log[k] !== 15'h10 + 15'(k)) begin errors++; $display("FAIL basic_rd_addr%0d: got %h want %h", k, rd_log[k], 15'h10 + 15'(k)); end
         end
      end
      cs_stop(0);
      checks++; if (busy !== 1'b0 || spi_miso_oe !== 1'b0) begin errors++; $display("FAIL basic_release: got busy=%b oe=%b want 0 0", busy, spi_miso_oe); end
      checks++; if (bytes_sent !== 16'd4) begin errors++; $display("FAIL basic_bytes_hold: got %0d want 4", bytes_sent); end
   endtask

   task automatic test_wrap();
      logic [7:0]  tx [0:7];
      logic [14:0] ea [0:4];
      logic [7:0]  rx, exp;
      // 0xFF high byte: surplus MSB above ADDR_WIDTH is dropped, giving 0x7FFE.
      tx = '{8'h0B, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      ea = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001, 15'h0002};
      rd_log.delete();
      repeat (4) exp_q.push_back(8'h00);
      for (int k = 0; k < 4; k++) exp_q.push_back(mem_f(ea[k]));
      cs_start(0);
      checks++; if (bytes_sent !== 16'd0) begin errors++; $display("FAIL wrap_bytes_clear: got %0d want 0", bytes_sent); end
      for (int i = 0; i < 8; i++) begin
         spi_xfer(tx[i], 8, 0, rx);
         exp = exp_q.pop_front();
         checks++; if (rx !== exp) begin errors++; $display("FAIL wrap_byte%0d: got %02h want %02h", i, rx, exp); end
      end
      #60;
      checks++; if ($isunknown(bram_rd_addr)) begin errors++; $display("FAIL wrap_addr_x: got %h want known", bram_rd_addr); end
      checks++;
      if (rd_log.size() < 5) begin
         errors++; $display("FAIL wrap_rd_count: got %0d want >=5", rd_log.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            checks++; if (rd_log[k] !== ea[k]) begin errors++; $display("FAIL wrap_rd_addr%0d: got %h want %h", k, rd_log[k], ea[k]); end
         end
      end
      cs_stop(0);
      // Small buffer: start 0x0500 is beyond 1024 bytes, so reading starts at 0.
      rd_log2.delete();
      tx = '{8'h0B, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      repeat (4) exp_q.push_back(8'h00);
      exp_q.push_back(mem_f(15'h0)); exp_q.push_back(mem_f(15'h1));
      cs_start(1);
      for (int i = 0; i < 6; i++) begin
         spi_xfer(tx[i], 8, 1, rx);
         exp = exp_q.pop_front();
         checks++; if (rx !== exp) begin errors++; $display("FAIL small_byte%0d: got %02h want %02h", i, rx, exp); end
      end
      #60;
      checks++;
      if (rd_log2.size() < 2) begin
         errors++; $display("FAIL small_rd_count: got %0d want >=2", rd_log2.size());
      end else begin
         checks++; if (rd_log2[0] !== 15'h0 || rd_log2[1] !== 15'h1) begin errors++; $display("FAIL small_rd_addr: got %h,%h want 0000,0001", rd_log2[0], rd_log2[1]); end
      end
      cs_stop(1);
   endtask

   task automatic test_status();
      logic [7:0] rx, exp;
      frame_ready = 1'b1;
      receiving   = 1'b0;
      rd_log.delete();
      exp_q.push_back(8'h00);
      repeat (3) exp_q.push_back(8'h81);
      cs_start(0);
      spi_xfer(8'h05, 8, 0, rx);
      exp = exp_q.pop_front();
      checks++; if (rx !== exp) begin errors++; $display("FAIL status_cmd: got %02h want %02h", rx, exp); end
      for (int i = 0; i < 3; i++) begin
         spi_xfer(8'h00, 8, 0, rx);
         exp = exp_q.pop_front();
         checks++; if (rx !== exp) begin errors++; $display("FAIL status_byte%0d: got %02h want %02h", i, rx, exp); end
      end
      // The byte already on the wire keeps the old value; the following one
      // picks up receiving=1.
      receiving = 1'b1;
      exp_q.push_back(8'h81);
      exp_q.push_back(8'hC1);
      for (int i = 0; i < 2; i++) begin
         spi_xfer(8'h00, 8, 0, rx);
         exp = exp_q.pop_front();
         checks++; if (rx !== exp) begin errors++; $display("FAIL status_toggle%0d: got %02h want %02h", i, rx, exp); end
      end
      checks++; if (rd_log.size() != 0) begin errors++; $display("FAIL status_no_reads: got %0d want 0", rd_log.size()); end
      cs_stop(0);
      receiving = 1'b0;
   endtask

   task automatic test_ignore();
      logic [7:0] rx, exp;
      rd_log.delete();
      repeat (4) exp_q.push_back(8'h00);
      cs_start(0);
      for (int i = 0; i < 4; i++) begin
         spi_xfer((i == 0) ? 8'h9F : 8'hFF, 8, 0, rx);
         exp = exp_q.pop_front();
         checks++; if (rx !== exp) begin errors++; $display("FAIL ignore_byte%0d: got %02h want %02h", i, rx, exp); end
      end
      #60;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b want 1", busy); end
      checks++; if (rd_log.size() != 0) begin errors++; $display("FAIL ignore_no_reads: got %0d want 0", rd_log.size()); end
      cs_stop(0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_release: got %b want 0", busy); end
   endtask

   task automatic test_abort();
      logic [7:0] tx [0:5];
      logic [7:0] rx, exp;
      tx = '{8'h0B, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
      repeat (4) exp_q.push_back(8'h00);
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'hB2);
      cs_start(0);
      for (int i = 0; i < 5; i++) begin
         spi_xfer(tx[i], 8, 0, rx);
         exp = exp_q.pop_front();
         checks++; if (rx !== exp) begin errors++; $display("FAIL abort_byte%0d: got %02h want %02h", i, rx, exp); end
      end
      spi_xfer(8'h00, 3, 0, rx);
      exp = exp_q.pop_front();
      checks++; if (rx[7:5] !== exp[7:5]) begin errors++; $display("FAIL abort_partial: got %b want %b", rx[7:5], exp[7:5]); end
      rb_cs_n = 1'b1;
      repeat (4) @(posedge sys_clk);
      #1;
      checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b want 0", spi_miso_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
      #100;
      // A fresh transaction reads from its own address.
      rd_log.delete();
      tx = '{8'h0B, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00};
      repeat (4) exp_q.push_back(8'h00);
      exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
      cs_start(0);
      for (int i = 0; i < 6; i++) begin
         spi_xfer(tx[i], 8, 0, rx);
         exp = exp_q.pop_front();
         checks++; if (rx !== exp) begin errors++; $display("FAIL reread_byte%0d: got %02h want %02h", i, rx, exp); end
      end
      checks++;
      if (rd_log.size() < 1) begin
         errors++; $display("FAIL reread_rd_count: got 0 want >=1");
      end else begin
         checks++; if (rd_log[0] !== 15'h12) begin errors++; $display("FAIL reread_rd_addr: got %h want 0012", rd_log[0]); end
      end
      cs_stop(0);
   endtask

   task automatic test_reset_mid();
      logic [7:0] tx [0:4];
      logic [7:0] rx, exp;
      tx = '{8'h0B, 8'h00, 8'h10, 8'h00, 8'h00};
      repeat (4) exp_q.push_back(8'h00);
      exp_q.push_back(8'hA1);
      cs_start(0);
      for (int i = 0; i < 5; i++) begin
         spi_xfer(tx[i], 8, 0, rx);
         exp = exp_q.pop_front();
         checks++; if (rx !== exp) begin errors++; $display("FAIL rstmid_byte%0d: got %02h want %02h", i, rx, exp); end
      end
      spi_xfer(8'h00, 4, 0, rx);
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      @(posedge sys_clk);
      #1;
      checks++; if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got oe=%b miso=%b want 0 0", spi_miso_oe, spi_miso); end
      checks++; if (busy !== 1'b0 || bram_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got busy=%b rd_en=%b want 0 0", busy, bram_rd_en); end
      checks++; if (bram_rd_addr !== 15'h0 || bytes_sent !== 16'h0) begin errors++; $display("FAIL rstmid_regs: got addr=%h bytes=%h want 0 0", bram_rd_addr, bytes_sent); end
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      // CS stays low after release: the bench clocks a full header anyway.
      rd_log.delete();
      oe_seen = 0;
      #100;
      for (int i = 0; i < 4; i++) begin
         spi_xfer(tx[i], 8, 0, rx);
         checks++; if (rx !== 8'h00) begin errors++; $display("FAIL rstmid_quiet%0d: got %02h want 00", i, rx); end
      end
      #60;
      checks++; if (oe_seen != 0) begin errors++; $display("FAIL rstmid_oe_activity: got %0d want 0", oe_seen); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      checks++; if (rd_log.size() != 0) begin errors++; $display("FAIL rstmid_no_reads: got %0d want 0", rd_log.size()); end
      cs_stop(0);
      // After CS has been seen high, a fresh fall starts a normal read.
      tx = '{8'h0B, 8'h00, 8'h11, 8'h00, 8'h00};
      repeat (4) exp_q.push_back(8'h00);
      exp_q.push_back(8'hB2);
      cs_start(0);
      for (int i = 0; i < 5; i++) begin
         spi_xfer(tx[i], 8, 0, rx);
         exp = exp_q.pop_front();
         checks++; if (rx !== exp) begin errors++; $display("FAIL resume_byte%0d: got %02h want %02h", i, rx, exp); end
      end
      cs_stop(0);
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_wrap();
      test_status();
      test_ignore();
      test_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/spi_buffer_readback.md
Name: spi_buffer_readback

Overview:
- SPI mode-0 slave transmitter that streams image-buffer contents back to the ESP32 over MISO. Used for frame-integrity checks and debug readback.
- Read-side counterpart of the SPI receive path. Shares esp_sclk/esp_mosi with the receive slave and has its own chip select, rb_cs_n.
- Decodes a command/address header, then reads the BSRAM buffer through a dedicated synchronous read port and shifts bytes out MSB-first.

Parameters:
- ADDR_WIDTH, 15: buffer address width.
- BUF_DEPTH, 32768: number of valid buffer bytes; read address wraps at BUF_DEPTH-1.
- VERSION, 6'h01: value reported in status bits [5:0].

Ports:
- sys_clk  in  1  system clock, 27 MHz.
- sys_rst_n  in  1  asynchronous, active-low reset.
- spi_sclk  in  1  SPI clock from ESP32, asynchronous.
- spi_mosi  in  1  SPI data from ESP32, asynchronous.
- rb_cs_n  in  1  readback chip select, active low, asynchronous.
- spi_miso  out  1  serial data to ESP32.
- spi_miso_oe  out  1  MISO drive enable; top tri-states or muxes MISO with this.
- bram_rd_en  out  1  one-cycle read strobe.
- bram_rd_addr  out  ADDR_WIDTH  buffer read address.
- bram_rd_data  in  8  read data, valid exactly 1 sys_clk after bram_rd_en.
- frame_ready  in  1  status input.
- receiving  in  1  status input.
- busy  out  1  transaction in progress.
- bytes_sent  out  16  data bytes loaded in current/last transaction, saturating at 16'hFFFF.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, bram_rd_en=0, bram_rd_addr=0, busy=0, bytes_sent=0; state=IDLE.
- Synchronization: spi_sclk, spi_mosi and rb_cs_n each pass through 2-flop synchronizers (reset to 1,0,1). Edge detection uses a third registered copy of sclk.
- SCLK constraint: spi_sclk ≤ sys_clk/8, with each phase ≥4 sys_clk.
- Sampling: MOSI is sampled on the synchronized SCLK rise. MISO updates on the synchronized SCLK fall.
- Bit counter: 3-bit, cleared on CS assertion. Byte boundary = 8th rise.
- spi_miso_oe = synchronized CS asserted. spi_miso = shift_reg[7] while oe, else 0.
- FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, DUMMY, DATA, STATUS, IGNORE.
  - IDLE → CMD on synchronized CS falling. busy=1; bytes_sent=0; shift_reg=0.
  - CMD at byte boundary: 8'h0B → ADDR_HI. 8'h05 → STATUS, with status_byte = {frame_ready, receiving, VERSION} latched. Any other value → IGNORE.
  - ADDR_HI: the 8 bits received form address bits [15:8]. Only [ADDR_WIDTH-1:8] are kept; surplus MSBs are ignored.
  - ADDR_LO: the 8 bits received form address bits [7:0]. At the byte boundary:
    - a start address ≥ BUF_DEPTH is replaced by 0;
    - issue bram_rd_en for one cycle at that address;
    - go to DUMMY.
  - DUMMY: MISO outputs 0. The returned data is captured into prefetch_reg 1 cycle after the strobe; addr increments. At the 8th fall, shift_reg ← prefetch_reg and the next read is issued; → DATA.
  - DATA: at each 8th fall, load shift_reg from prefetch_reg, increment bytes_sent (saturating), and issue the next read at addr, post-incremented. The prefetch completes ≥3 sys_clk before the next load.
  - Address wrap: BUF_DEPTH-1 → 0.
  - STATUS: shift_reg ← status_byte at every 8th fall, so the status byte repeats. status_byte is re-latched at each byte boundary.
  - IGNORE: shift_reg held 0. Stays until CS deasserts.
- First-bit rule: bit 7 of each outgoing byte is on MISO from the 8th fall of the previous byte, so it is valid before the first rise.
- CS deassert in any state, mid-byte included: next cycle → IDLE, oe=0, miso=0, busy=0, bram_rd_en=0. bytes_sent holds its value until the next CS fall.
- CS deassert and SCLK edge in the same cycle: CS wins; the edge is ignored.
- Reset mid-transaction: immediate return to reset values. A transaction resumes only after a fresh CS fall.
- SCLK edges while CS is high are ignored.

Test Plan:
- Buffer bytes 0x10..0x13 = A1,B2,C3,D4. Send 0B 00 10, dummy, 4 bytes → MISO returns 00 00 00 00 A1 B2 C3 D4. bytes_sent=4; bram_rd_addr sequence 0x10..0x14.
- Start at 0x7FFE, read 4 bytes → data from 7FFE, 7FFF, 0000, 0001. No X on address. Repeat with BUF_DEPTH=1024 and start 0x0500 → reads begin at 0.
- frame_ready=1, receiving=0. Send 05 then 3 bytes → MISO 00, 81, 81, 81. Toggle receiving mid-stream → next byte C1.
- Command 0x9F plus 3 bytes → all MISO bytes 00. No bram_rd_en pulses. busy=1 until CS high.
- Raise CS after 3 bits of data byte 2 → oe=0 within 4 sys_clk; state IDLE. A new 0B transaction reads correctly from its own address.
- Assert sys_rst_n low during DATA → all outputs at reset values next edge. After release with no CS edge: no MISO activity.
